scan_select_sequencer: RTL and testbench
========================================

SCAN_SELECT_SEQUENCER -- requirements
Module: scan_select_sequencer

Interface
REQ-001 SHALL have parameter: DWELL_W, 8, width of the dwell count.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port: stop  input  1  abort the current sweep.
REQ-006 SHALL have port: continuous  input  1  when 1, the sweep wraps instead of ending.
REQ-007 SHALL have port: mask_lines  input  8  enabled select indices; bit i enables index i.
REQ-008 SHALL have port: dwell  input  DWELL_W  extra hold cycles per index.
REQ-009 SHALL have port: sel_lines  output  3  current select index for the downstream 3-to-8 decoder.
REQ-010 SHALL have port: sel_valid  output  1  sel_lines is meaningful.
REQ-011 SHALL have port: busy  output  1  sweep in progress.
REQ-012 SHALL have port: done  output  1  one-cycle pulse at sweep end.

Function
REQ-013 SHALL implement FSM states IDLE, DWELL and FIN.
REQ-014 SHALL, in IDLE on start=1 and stop=0, latch mask_lines and dwell.
REQ-015 SHALL then, if the latched mask is nonzero, enter DWELL with sel_lines = lowest set index and the counter = dwell; sel_valid becomes 1 on the next cycle, giving a latency of 1.
REQ-016 SHALL, on start with mask==0, enter FIN directly; sel_valid is never asserted.
REQ-017 SHALL, in DWELL, decrement the counter each cycle; each index is held for exactly dwell+1 cycles, and dwell=0 gives 1 cycle per index.
REQ-018 SHALL, at counter==0, advance sel_lines to the next set mask bit above the current index (ascending order) and reload the counter.
REQ-019 SHALL, when no higher set bit exists, wrap to the lowest set index if continuous==1 (sampled live at that cycle), otherwise enter FIN.
REQ-020 SHALL, in FIN, assert done for exactly one cycle and then return to IDLE.
REQ-021 SHALL hold the same index for every cycle with no gap when the mask has a single set bit and continuous=1.
REQ-022 SHALL, on stop=1 in DWELL, go to IDLE next cycle with no done pulse; stop has priority over the counter advance.
REQ-023 SHALL give stop priority over start when both are asserted in IDLE, so the block remains in IDLE.
REQ-024 SHALL ignore start while busy; changes to mask_lines or dwell while busy have no effect.
REQ-025 SHALL drive busy=1 exactly in DWELL and FIN, and sel_valid=1 exactly in DWELL.
REQ-026 SHALL drive sel_lines=0 whenever sel_valid=0.
REQ-027 SHALL register all outputs, with no combinational input-to-output path.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, go to IDLE and force sel_lines=0, sel_valid=0, busy=0, done=0, counter=0 and the latched mask=0.
REQ-029 SHALL, on rst mid-sweep, abort with no done pulse; rst overrides start and stop.

Configuration
REQ-030 SHALL, with SCAN_ONEHOT_OUT_EN defined, add output port onehot_lines[7:0] = registered 1<<sel_lines when sel_valid=1, else 0; it is 0 after reset and aligned cycle-for-cycle with sel_lines.
REQ-031 SHALL, without SCAN_ONEHOT_OUT_EN, omit the port and its logic entirely; all other behaviour is identical.

Structure
REQ-032 SHALL place in shared package scan_seq_pkg: NUM_LINES=8, SEL_W=3, and the FSM state enum (IDLE, DWELL, FIN).
REQ-033 SHALL implement the next-enabled-index search (current index, mask, returning found flag, next index and lowest index) as combinational sub-module scan_next_index.

Verification
REQ-034 SHALL cover: mask=8'b1010_0100, dwell=2, continuous=0, start -> sel 2,5,7 each valid 3 cycles; done pulses 1 cycle after the last hold ends; busy for 10 cycles.
REQ-035 SHALL cover: mask=8'hFF, dwell=0, continuous=1 -> sel 0..7,0,1... one per cycle; clear continuous during index 7 -> FIN after 7, done=1.
REQ-036 SHALL cover: mask=8'h00, start -> done=1 on cycle 2 and sel_valid never 1.
REQ-037 SHALL cover: stop asserted during the 2nd index of a sweep -> IDLE next cycle, sel_valid=0, sel_lines=0, no done; start with stop in the same cycle -> nothing starts.
REQ-038 SHALL cover: rst during DWELL with mask=8'h81 -> all outputs 0 next cycle; start re-asserted while busy -> ignored, sequence unchanged.
REQ-039 SHALL cover, with SCAN_ONEHOT_OUT_EN: mask=8'h81 -> onehot_lines 8'h01 then 8'h80, 0 when idle.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared constants, FSM state type and mask helper for the scan select sequencer.
package scan_seq_pkg;

    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned SEL_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        FIN   = 2'd2
    } state_e;

    // Lowest set index of a mask; returns 0 for an empty mask.
    function automatic logic [SEL_W-1:0] lowest_index(input logic [NUM_LINES-1:0] mask);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (mask[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_next_index.sv
// Combinational search for the next enabled select index above the current one,
// plus the lowest enabled index for wrap-around.
module scan_next_index
    import scan_seq_pkg::*;
(
    input  logic [SEL_W-1:0]     cur_idx,
    input  logic [NUM_LINES-1:0] mask,
    output logic                 found_c,
    output logic [SEL_W-1:0]     next_idx_c,
    output logic [SEL_W-1:0]     lowest_idx_c
);

    // Descending scan so the last hit is the smallest index above cur_idx.
    always_comb begin
        found_c    = 1'b0;
        next_idx_c = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (mask[i] && (SEL_W'(i) > cur_idx)) begin
                found_c    = 1'b1;
                next_idx_c = SEL_W'(i);
            end
        end
        lowest_idx_c = lowest_index(mask);
    end

endmodule

// File: rtl/scan_select_sequencer.sv
// Sweeps a 3-bit select index over the enabled mask bits with a programmable dwell.
// Optional SCAN_ONEHOT_OUT_EN adds a registered one-hot copy of the select index.
module scan_select_sequencer
    import scan_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [NUM_LINES-1:0] mask_lines,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [SEL_W-1:0]     sel_lines,
    output logic                 sel_valid,
    output logic                 busy,
    output logic                 done
`ifdef SCAN_ONEHOT_OUT_EN
    ,
    output logic [NUM_LINES-1:0] onehot_lines
`endif
);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 sel_valid_q, sel_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [NUM_LINES-1:0] mask_q, mask_d;

    logic                 found_c;
    logic [SEL_W-1:0]     next_idx_c;
    logic [SEL_W-1:0]     lowest_idx_c;

    scan_next_index u_next (
        .cur_idx      (sel_q),
        .mask         (mask_q),
        .found_c      (found_c),
        .next_idx_c   (next_idx_c),
        .lowest_idx_c (lowest_idx_c)
    );

    // Next state; outputs are derived from the next state so they register alongside it.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mask_d  = mask_lines;
                    dwell_d = dwell;
                    if (mask_lines != '0) begin
                        state_d = DWELL;
                        sel_d   = lowest_index(mask_lines);
                        cnt_d   = dwell;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            DWELL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (found_c) begin
                    sel_d = next_idx_c;
                    cnt_d = dwell_q;
                end else if (continuous) begin
                    sel_d = lowest_idx_c;
                    cnt_d = dwell_q;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sel_valid_d = (state_d == DWELL);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
        if (!sel_valid_d) sel_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
        end
    end

    assign sel_lines = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef SCAN_ONEHOT_OUT_EN
    logic [NUM_LINES-1:0] onehot_q, onehot_d;

    always_comb begin
        onehot_d = '0;
        if (sel_valid_d) onehot_d = NUM_LINES'(1) << sel_d;
    end

    always_ff @(posedge clk) begin
        if (rst) onehot_q <= '0;
        else     onehot_q <= onehot_d;
    end

    assign onehot_lines = onehot_q;
`endif

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Randomized and directed bench for scan_select_sequencer against a cycle-level reference model.
module tb_scan_select_sequencer;

    localparam int unsigned DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               continuous;
    logic [7:0]         mask_lines;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel_lines;
    logic               sel_valid;
    logic               busy;
    logic               done;
`ifdef SCAN_ONEHOT_OUT_EN
    logic [7:0]         onehot_lines;
`endif

    always #5 clk = ~clk;

    scan_select_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .mask_lines   (mask_lines),
        .dwell        (dwell),
        .sel_lines    (sel_lines),
        .sel_valid    (sel_valid),
        .busy         (busy),
        .done         (done)
`ifdef SCAN_ONEHOT_OUT_EN
        ,
        .onehot_lines (onehot_lines)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = holding an index, 2 = finishing.
    int         m_mode;
    int         m_idx;
    int         m_left;
    int         m_dwell;
    logic [7:0] m_mask;

    function automatic int lowest_of(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int above(input logic [7:0] m, input int cur);
        for (int i = cur + 1; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        int nxt;
        if (rst) begin
            m_mode = 0; m_idx = 0; m_left = 0; m_dwell = 0; m_mask = '0;
        end else if (m_mode == 0) begin
            if (start && !stop) begin
                m_mask  = mask_lines;
                m_dwell = int'(dwell);
                if (mask_lines == 8'h00) m_mode = 2;
                else begin
                    m_mode = 1; m_idx = lowest_of(mask_lines); m_left = m_dwell;
                end
            end
        end else if (m_mode == 1) begin
            if (stop) m_mode = 0;
            else if (m_left > 0) m_left--;
            else begin
                nxt = above(m_mask, m_idx);
                if (nxt >= 0) begin m_idx = nxt; m_left = m_dwell; end
                else if (continuous) begin m_idx = lowest_of(m_mask); m_left = m_dwell; end
                else m_mode = 2;
            end
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic check_outputs();
        int e_sel;
        e_sel = (m_mode == 1) ? m_idx : 0;
        check("sel_lines", 32'(sel_lines), 32'(e_sel));
        check("sel_valid", 32'(sel_valid), 32'(m_mode == 1));
        check("busy",      32'(busy),      32'(m_mode != 0));
        check("done",      32'(done),      32'(m_mode == 2));
`ifdef SCAN_ONEHOT_OUT_EN
        check("onehot", 32'(onehot_lines), (m_mode == 1) ? (32'd1 << e_sel) : 32'd0);
`endif
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int nb;
        int ndone;
        int nvalid;
        int last_sel;
        bit hit;
        int seq[$];

        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        mask_lines = 8'h00; dwell = '0;
        m_mode = 0; m_idx = 0; m_left = 0; m_dwell = 0; m_mask = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_sel", 32'(sel_lines), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Three-index one-shot sweep with dwell 2.
        mask_lines = 8'b1010_0100; dwell = 8'd2;
        pulse_start();
        nb = 1; ndone = 0; last_sel = -1; seq.delete();
        if (sel_valid) begin seq.push_back(int'(sel_lines)); last_sel = int'(sel_lines); end
        for (int c = 0; c < 14; c++) begin
            step();
            if (busy) nb++;
            if (done) ndone++;
            if (sel_valid && int'(sel_lines) != last_sel) begin
                seq.push_back(int'(sel_lines)); last_sel = int'(sel_lines);
            end
        end
        check("sweep_busy_cycles", 32'(nb), 32'd10);
        check("sweep_done_cycles", 32'(ndone), 32'd1);
        check("sweep_len", 32'(seq.size()), 32'd3);
        if (seq.size() == 3) begin
            check("sweep_idx0", 32'(seq[0]), 32'd2);
            check("sweep_idx1", 32'(seq[1]), 32'd5);
            check("sweep_idx2", 32'(seq[2]), 32'd7);
        end

        // Full mask continuous, then release continuous on index 7.
        mask_lines = 8'hFF; dwell = 8'd0; continuous = 1'b1;
        pulse_start();
        for (int c = 0; c < 11; c++) step();
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (m_mode == 1 && m_idx == 7) hit = 1'b1;
            else step();
        end
        check("wait_idx7", 32'(hit), 32'd1);
        continuous = 1'b0;
        step();
        check("cont_release_done", 32'(done), 32'd1);
        step();
        step();

        // Empty mask: straight to the done pulse, never valid.
        mask_lines = 8'h00;
        pulse_start();
        check("empty_done", 32'(done), 32'd1);
        nvalid = 0;
        for (int c = 0; c < 3; c++) begin step(); if (sel_valid) nvalid++; end
        check("empty_never_valid", 32'(nvalid), 32'd0);

        // Stop during the second index; then start together with stop.
        mask_lines = 8'b1010_0100; dwell = 8'd2;
        pulse_start();
        for (int c = 0; c < 3; c++) step();
        check("stop_at_idx5", 32'(sel_lines), 32'd5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_valid", 32'(sel_valid), 32'd0);
        ndone = 0;
        for (int c = 0; c < 3; c++) begin step(); if (done) ndone++; end
        check("stop_no_done", 32'(ndone), 32'd0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 32'(busy), 32'd0);

        // Start while busy ignored; reset mid-dwell clears everything.
        mask_lines = 8'h81; dwell = 8'd3;
        pulse_start();
        step();
        mask_lines = 8'h10; dwell = 8'd0;
        pulse_start();
        check("busy_start_idx", 32'(sel_lines), 32'd0);
        for (int c = 0; c < 3; c++) step();
        check("busy_start_idx7", 32'(sel_lines), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", 32'(sel_valid), 32'd0);
        check("midrst_done", 32'(done), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            start      = ($urandom % 6) == 0;
            stop       = ($urandom % 40) == 0;
            if (($urandom % 16) == 0) continuous = ~continuous;
            mask_lines = (($urandom % 10) == 0) ? 8'h00 : 8'($urandom);
            dwell      = DWELL_W'($urandom % 4);
            rst        = ($urandom % 250) == 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
